xnor_seq_ctrl: RTL and testbench



---
 rtl/xnor_seq_pkg.sv | 24 ++
 rtl/xnor_seq_ctrl_if.sv | 29 ++
 rtl/xnor_cell.sv | 16 +
 rtl/xnor_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_xnor_seq_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/xnor_seq_pkg.sv
// Shared types for the time-multiplexed XNOR equality engine: FSM encoding,
// requester IDs and the round-robin pick.
package xnor_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // A tie goes to whoever did not own the previous grant.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_owner);
    logic sel;
    if (req0 && req1) sel = ~last_owner;
    else if (req1)    sel = REQ1;
    else              sel = REQ0;
    return sel;
  endfunction

endpackage

// File: rtl/xnor_seq_ctrl_if.sv
// Request/operand/result bundle between two requesters and the equality engine.
interface xnor_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             owner;
  logic             eq;
  logic [IDXW-1:0]  mm_idx;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, owner, eq, mm_idx
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, owner, eq, mm_idx
  );
endinterface

// File: rtl/xnor_cell.sv
// Single-bit equality gate, x = ~(a ^ b), composed only of 2-input NORs.
module xnor_cell (
  input  wire a_i,
  input  wire b_i,
  output wire x_o
);
  wire n_ab;
  wire n_a;
  wire n_b;

  // n_a = ~a & b, n_b = a & ~b; NOR of the two is the XNOR.
  nor g_ab  (n_ab, a_i, b_i);
  nor g_a   (n_a,  a_i, n_ab);
  nor g_b   (n_b,  b_i, n_ab);
  nor g_out (x_o,  n_a, n_b);
endmodule

// File: rtl/xnor_seq_ctrl.sv
// Round-robin shared equality engine: latches one requester's operands and
// walks them LSB-first through a single XNOR cell, reporting eq and lowest mismatch.
module xnor_seq_ctrl
  import xnor_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            reset,
  xnor_seq_ctrl_if.slave bus
);

  localparam int unsigned     CNTW     = IDXW + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             found_q, found_d;
  logic [IDXW-1:0]  mm_r_q, mm_r_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic [IDXW-1:0]  mm_idx_q, mm_idx_d;

  logic            sel_c;
  logic            grant_c;
  logic            gnt0_c;
  logic            gnt1_c;
  logic            x_c;
  logic [IDXW-1:0] cnt_idx;

  assign cnt_idx = cnt_q[IDXW-1:0];
  assign sel_c   = rr_pick(bus.req0, bus.req1, last_owner_q);
  // Grant is combinational but suppressed while reset is held.
  assign grant_c = (state_q == S_IDLE) && (bus.req0 || bus.req1) && !reset;

  xnor_cell u_cell (
    .a_i (a_sh_q[cnt_idx]),
    .b_i (b_sh_q[cnt_idx]),
    .x_o (x_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      found_q      <= 1'b0;
      mm_r_q       <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= REQ1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      eq_q         <= 1'b0;
      mm_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      found_q      <= found_d;
      mm_r_q       <= mm_r_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      eq_q         <= eq_d;
      mm_idx_q     <= mm_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    found_d      = found_q;
    mm_r_d       = mm_r_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    eq_d         = eq_q;
    mm_idx_d     = mm_idx_q;
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_c) begin
          gnt0_c       = (sel_c == REQ0);
          gnt1_c       = (sel_c == REQ1);
          a_sh_d       = (sel_c == REQ1) ? bus.a1 : bus.a0;
          b_sh_d       = (sel_c == REQ1) ? bus.b1 : bus.b0;
          cnt_d        = '0;
          acc_d        = 1'b1;
          found_d      = 1'b0;
          owner_d      = sel_c;
          last_owner_d = sel_c;
          busy_d       = 1'b1;
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        acc_d  = acc_q & x_c;
        if (!x_c && !found_q) begin
          found_d = 1'b1;
          mm_r_d  = cnt_idx;
        end
        // Results are folded in with the last bit so they are valid during done.
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          eq_d     = acc_d;
          mm_idx_d = found_d ? mm_r_d : '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.gnt0   = gnt0_c;
  assign bus.gnt1   = gnt1_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.owner  = owner_q;
  assign bus.eq     = eq_q;
  assign bus.mm_idx = mm_idx_q;

endmodule

// File: tb/tb_xnor_seq_ctrl.sv
// Scoreboard bench for xnor_seq_ctrl: stimulus queues expected grants/results,
// a negedge monitor pops and compares them as the DUT presents gnt/done.
module tb_xnor_seq_ctrl;

  typedef struct packed {
    logic       owner;
    logic       eq;
    logic [2:0] idx;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic exp_gnt_q[$];
  res_t exp_res_q[$];

  int   gnt_cyc = 0;
  int   busy_cnt = 0;
  res_t r;
  logic g;

  xnor_seq_ctrl_if #(.WIDTH(8)) bus ();

  xnor_seq_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: grants and done pulses are matched against the expected queues.
  always @(negedge clk) begin
    if (bus.gnt0 || bus.gnt1) begin
      check("gnt_expected", 32'(exp_gnt_q.size() != 0), 32'd1);
      if (exp_gnt_q.size() != 0) begin
        g = exp_gnt_q.pop_front();
        check("gnt_onehot", {30'd0, bus.gnt1, bus.gnt0}, (g == 1'b1) ? 32'd2 : 32'd1);
      end
      check("busy_at_gnt", 32'(bus.busy), 32'd0);
      gnt_cyc  = cyc;
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end
    if (bus.done) begin
      check("done_expected", 32'(exp_res_q.size() != 0), 32'd1);
      if (exp_res_q.size() != 0) begin
        r = exp_res_q.pop_front();
        check("owner",   32'(bus.owner),  32'(r.owner));
        check("eq",      32'(bus.eq),     32'(r.eq));
        check("mm_idx",  32'(bus.mm_idx), 32'(r.idx));
        check("latency", 32'(cyc - gnt_cyc), 32'd9);
        check("busy_len", 32'(busy_cnt), 32'd9);
      end
    end
  end

  task automatic wait_gnt(input int bound);
    logic got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        got = 1'b1;
        break;
      end
    end
    check("gnt_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_done();
    logic got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic single(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic eq, input logic [2:0] idx);
    exp_gnt_q.push_back(id);
    exp_res_q.push_back('{owner: id, eq: eq, idx: idx});
    @(posedge clk); #1;
    if (id) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
    else    begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
    wait_gnt(4);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_owner"},  32'(bus.owner),  32'd0);
    check({tag, "_eq"},     32'(bus.eq),     32'd0);
    check({tag, "_mm_idx"}, 32'(bus.mm_idx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t_prev;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    reset = 1'b0;

    // Basic compares: equal, high-bit mismatch, lowest of two mismatches.
    single(1'b0, 8'hA5, 8'hA5, 1'b1, 3'd0);
    single(1'b1, 8'hF0, 8'hB0, 1'b0, 3'd6);
    single(1'b0, 8'h00, 8'h81, 1'b0, 3'd0);

    // Operand change after grant is ignored; a short req1 pulse while busy is dropped.
    exp_gnt_q.push_back(1'b0);
    exp_res_q.push_back('{owner: 1'b0, eq: 1'b1, idx: 3'd0});
    @(posedge clk); #1;
    bus.a0 = 8'h12; bus.b0 = 8'h12; bus.req0 = 1'b1;
    wait_gnt(4);
    @(posedge clk); #1 bus.req0 = 1'b0;
    @(posedge clk); #1;
    bus.a0 = 8'hFF; bus.a1 = 8'h00; bus.b1 = 8'h01; bus.req1 = 1'b1;
    @(posedge clk); #1 bus.req1 = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);

    // Reset mid-operation: outputs clear at once, no done, held req0 granted after release.
    exp_gnt_q.push_back(1'b1);
    @(posedge clk); #1;
    bus.a1 = 8'h00; bus.b1 = 8'h01; bus.req1 = 1'b1;
    wait_gnt(4);
    @(posedge clk); #1 bus.req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.a0 = 8'h55; bus.b0 = 8'h55; bus.req0 = 1'b1;
    reset = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    exp_gnt_q.push_back(1'b0);
    exp_res_q.push_back('{owner: 1'b0, eq: 1'b1, idx: 3'd0});
    #1 reset = 1'b0;
    wait_gnt(2);
    @(posedge clk); #1 bus.req0 = 1'b0;
    wait_done();

    // Both requesters held from reset: strict alternation 0,1,0 ten cycles apart.
    @(posedge clk); #1 reset = 1'b1;
    bus.a0 = 8'h3C; bus.b0 = 8'h3C; bus.a1 = 8'h3C; bus.b1 = 8'h3C;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    exp_gnt_q.push_back(1'b0);
    exp_res_q.push_back('{owner: 1'b0, eq: 1'b1, idx: 3'd0});
    exp_res_q.push_back('{owner: 1'b1, eq: 1'b1, idx: 3'd0});
    exp_res_q.push_back('{owner: 1'b0, eq: 1'b1, idx: 3'd0});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(12);
      if (k > 0) check("gnt_spacing", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);

    check("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
